// File: rtl/dma_cpl_router_pkg.sv
// dma_cpl_router_pkg: shared types, default sizes and helpers for the DMA completion router
//  cpl_trk_t  : tracked request record {rid, ctl} at the default region-ID width
//  popcnt16   : number of set bits in a 16-bit vector (up to 16 regions)
package dma_cpl_router_pkg;
  localparam int CPL_RID_BITS = 4;
  localparam int CPL_TRK_DEPTH = 32;
  localparam int CPL_MAX_REGIONS = 16;
  typedef struct packed {
    logic [CPL_RID_BITS-1:0] rid;
    logic                    ctl;
  } cpl_trk_t;
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    popcnt16 = '0;
    for (int i = 0; i < 16; i++) popcnt16 += 5'(v[i]);
  endfunction
endpackage

// File: rtl/dma_cpl_router_cpl_trk_fifo.sv
// cpl_trk_fifo: synchronous FIFO of request records, no bypass (a push is visible at dout next cycle)
//  clk/rst     : clock, synchronous active-high reset
//  push/din    : write record (ignored when full)
//  pop/dout    : read head (ignored when empty); dout is the current head
//  count/full/empty : occupancy status
module cpl_trk_fifo
  import dma_cpl_router_pkg::*;
#(
  parameter int W = CPL_RID_BITS + 1,
  parameter int DEPTH = CPL_TRK_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dma_cpl_router.sv
// dma_cpl_router: tracks granted DMA requests in issue order and routes in-order done pulses to region TLBs
//  aclk/areset          : clock, synchronous active-high reset
//  s_iss_valid/ready    : granted request handshake; ready is registered (credit available)
//  s_iss_rid/ctl        : owning region, whether a done token is wanted
//  s_done               : in-order done pulse from the DMA engine (no backpressure)
//  m_done_valid/ready   : per-region done token handshake
//  outstanding          : in-flight credits = FIFO occupancy + pending tokens
//  err_unexp            : sticky, done with empty tracker or token for a nonexistent region
module dma_cpl_router
  import dma_cpl_router_pkg::*;
#(
  parameter int N_REGIONS = 1,
  parameter int DEPTH = CPL_TRK_DEPTH,
  parameter int RID_BITS = CPL_RID_BITS,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_iss_valid,
  output logic                 s_iss_ready,
  input  logic [RID_BITS-1:0]  s_iss_rid,
  input  logic                 s_iss_ctl,
  input  logic                 s_done,
  output logic [N_REGIONS-1:0] m_done_valid,
  input  logic [N_REGIONS-1:0] m_done_ready,
  output logic [CW-1:0]        outstanding,
  output logic                 err_unexp
);
  typedef struct packed {
    logic [RID_BITS-1:0] rid;
    logic                ctl;
  } trk_t;
  trk_t din, head;
  logic push, pop, tok, drop, free, full, empty;
  logic [CW-1:0] occ, out_next;
  logic [N_REGIONS-1:0] hs;
  assign din = '{rid: s_iss_rid, ctl: s_iss_ctl};
  assign push = s_iss_valid & s_iss_ready & ~full;
  // empty is registered, so a same-cycle push never satisfies a done
  assign pop = s_done & ~empty;
  assign tok = pop & head.ctl;
  assign drop = tok & (int'(head.rid) >= N_REGIONS);
  // a popped entry frees its credit now unless it becomes a pending token
  assign free = (pop & ~head.ctl) | drop;
  assign hs = m_done_valid & m_done_ready;
  assign out_next = outstanding + CW'(push) - CW'(free) - CW'(popcnt16(16'(hs)));
  cpl_trk_fifo #(.W($bits(trk_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(aclk), .rst(areset), .push(push), .din(din), .pop(pop),
    .dout(head), .count(occ), .full(full), .empty(empty)
  );
  for (genvar r = 0; r < N_REGIONS; r++) begin : g_reg
    logic [CW-1:0] pend;
    logic inc;
    assign inc = tok && int'(head.rid) == r;
    assign m_done_valid[r] = pend != '0;
    always_ff @(posedge aclk) pend <= areset ? '0 : pend + CW'(inc) - CW'(hs[r]);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      outstanding <= '0;
      s_iss_ready <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      outstanding <= out_next;
      s_iss_ready <= out_next < CW'(DEPTH);
      err_unexp <= err_unexp | (s_done & empty) | drop;
    end
  end
  always_ff @(posedge aclk) if (!areset) a_credit : assert (outstanding >= occ);
endmodule

// File: tb/tb_dma_cpl_router.sv
module tb_dma_cpl_router;
  localparam int NR = 4, D = 32, RB = 4, CW = 6;
  logic clk = 0;
  always #5 clk = ~clk;
  logic areset = 1, iv = 0, ictl = 0, idone = 0;
  logic [RB-1:0] irid = 0;
  logic [NR-1:0] ird = 0;
  logic rdy, err;
  logic [NR-1:0] dv;
  logic [CW-1:0] outs;
  int vectors = 0, miscompares = 0;

  dma_cpl_router #(.N_REGIONS(NR), .DEPTH(D), .RID_BITS(RB)) dut (
    .aclk(clk), .areset(areset), .s_iss_valid(iv), .s_iss_ready(rdy), .s_iss_rid(irid),
    .s_iss_ctl(ictl), .s_done(idone), .m_done_valid(dv), .m_done_ready(ird),
    .outstanding(outs), .err_unexp(err)
  );

  typedef struct {int rid; bit ctl;} ent_t;
  ent_t q[$];
  int pend[NR];
  bit m_err = 0, m_rdy = 0;

  function automatic int m_out();
    int s = q.size();
    foreach (pend[i]) s += pend[i];
    return s;
  endfunction
  function automatic logic [NR-1:0] m_valid();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = pend[i] != 0;
    return v;
  endfunction

  task automatic model_step();
    ent_t h;
    if (areset) begin
      q.delete();
      foreach (pend[i]) pend[i] = 0;
      m_err = 0;
      m_rdy = 0;
      return;
    end
    for (int r = 0; r < NR; r++) if (pend[r] != 0 && ird[r]) pend[r]--;
    if (idone) begin
      if (q.size() == 0) m_err = 1;
      else begin
        h = q.pop_front();
        if (h.ctl) begin
          if (h.rid < NR) pend[h.rid]++;
          else m_err = 1;
        end
      end
    end
    if (iv && m_rdy) q.push_back('{int'(irid), ictl});
    m_rdy = m_out() < D;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle();
    iv = 0; idone = 0; ird = 0; ictl = 0; irid = 0;
  endtask

  task automatic test_reset();
    areset = 1; idle(); tick(); tick();
    vectors++; if (rdy !== 0) begin miscompares++; $display("FAIL reset_ready got %b want 0", rdy); end
    vectors++; if (dv !== 0) begin miscompares++; $display("FAIL reset_valid got %b want 0", dv); end
    vectors++; if (outs !== 0) begin miscompares++; $display("FAIL reset_outstanding got %0d want 0", outs); end
    vectors++; if (err !== 0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    areset = 0; tick();
    vectors++; if (rdy !== 1) begin miscompares++; $display("FAIL reset_ready_after got %b want 1", rdy); end
  endtask

  task automatic test_single();
    iv = 1; irid = 2; ictl = 1; tick(); idle();
    vectors++; if (outs !== 1) begin miscompares++; $display("FAIL single_out1 got %0d want 1", outs); end
    repeat (4) tick();
    idone = 1; tick(); idone = 0;
    vectors++; if (dv !== 4'b0100) begin miscompares++; $display("FAIL single_valid got %b want 0100", dv); end
    ird = 4'b0100; tick();
    vectors++; if (dv !== 4'b0000) begin miscompares++; $display("FAIL single_consumed got %b want 0000", dv); end
    vectors++; if (outs !== 0) begin miscompares++; $display("FAIL single_out0 got %0d want 0", outs); end
    tick(); ird = 0;
    vectors++; if (dv !== 0 || outs !== 0) begin miscompares++; $display("FAIL single_once got %b/%0d want 0/0", dv, outs); end
  endtask

  task automatic test_full();
    logic [RB-1:0] first;
    first = RB'($urandom_range(0, NR - 1));
    for (int i = 0; i < D; i++) begin
      iv = 1; ictl = 1; irid = (i == 0) ? first : RB'($urandom_range(0, NR - 1)); tick();
    end
    idle();
    vectors++; if (rdy !== 0) begin miscompares++; $display("FAIL full_ready got %b want 0", rdy); end
    vectors++; if (outs !== 6'(D)) begin miscompares++; $display("FAIL full_out got %0d want %0d", outs, D); end
    for (int i = 0; i < D; i++) begin idone = 1; tick(); end
    idone = 0;
    vectors++; if (rdy !== 0) begin miscompares++; $display("FAIL full_ready_done got %b want 0", rdy); end
    vectors++; if (dv !== m_valid()) begin miscompares++; $display("FAIL full_valid got %b want %b", dv, m_valid()); end
    ird = NR'(1) << first; tick(); ird = 0;
    vectors++; if (rdy !== 1) begin miscompares++; $display("FAIL full_release got %b want 1", rdy); end
    vectors++; if (outs !== 6'(D - 1)) begin miscompares++; $display("FAIL full_out31 got %0d want %0d", outs, D - 1); end
    ird = '1;
    for (int i = 0; i < 100 && m_out() != 0; i++) tick();
    ird = 0;
    vectors++; if (outs !== 0 || dv !== 0) begin miscompares++; $display("FAIL full_drain got %0d/%b want 0/0", outs, dv); end
  endtask

  task automatic test_interleave();
    int tok0 = 0, seen1 = 0;
    iv = 1; irid = 0; ictl = 1; tick();
    irid = 1; ictl = 0; tick();
    irid = 0; ictl = 1; tick();
    idle();
    vectors++; if (outs !== 3) begin miscompares++; $display("FAIL inter_out3 got %0d want 3", outs); end
    idone = 1; tick();
    vectors++; if (outs !== 3) begin miscompares++; $display("FAIL inter_pop1 got %0d want 3", outs); end
    tick();
    vectors++; if (outs !== 2) begin miscompares++; $display("FAIL inter_pop2 got %0d want 2", outs); end
    tick(); idone = 0;
    vectors++; if (dv !== 4'b0001) begin miscompares++; $display("FAIL inter_valid got %b want 0001", dv); end
    ird = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      if (dv[0]) tok0++;
      if (dv[1]) seen1++;
      tick();
    end
    ird = 0;
    vectors++; if (tok0 !== 2 || seen1 !== 0) begin miscompares++; $display("FAIL inter_tokens got %0d/%0d want 2/0", tok0, seen1); end
    vectors++; if (outs !== 0) begin miscompares++; $display("FAIL inter_out0 got %0d want 0", outs); end
  endtask

  task automatic test_simul();
    iv = 1; ictl = 0; irid = 0;
    repeat (5) tick();
    vectors++; if (outs !== 5) begin miscompares++; $display("FAIL simul_out5 got %0d want 5", outs); end
    idone = 1; tick(); iv = 0;
    vectors++; if (outs !== 5) begin miscompares++; $display("FAIL simul_pushpop got %0d want 5", outs); end
    repeat (5) tick();
    idle();
    vectors++; if (outs !== 0) begin miscompares++; $display("FAIL simul_drain got %0d want 0", outs); end
    iv = 1; irid = 1; ictl = 1; tick(); tick(); iv = 0;
    idone = 1; tick();
    idone = 1; ird = 4'b0010; tick(); idle();
    vectors++; if (dv !== 4'b0010 || outs !== 1) begin miscompares++; $display("FAIL simul_incdec got %b/%0d want 0010/1", dv, outs); end
    ird = 4'b0010; tick(); ird = 0;
    vectors++; if (dv !== 0 || outs !== 0) begin miscompares++; $display("FAIL simul_end got %b/%0d want 0/0", dv, outs); end
  endtask

  task automatic test_empty_done();
    areset = 1; tick(); areset = 0; tick();
    iv = 1; irid = 3; ictl = 1; idone = 1; tick(); idle();
    vectors++; if (err !== 1) begin miscompares++; $display("FAIL empty_err got %b want 1", err); end
    vectors++; if (outs !== 1) begin miscompares++; $display("FAIL empty_out got %0d want 1", outs); end
    tick();
    vectors++; if (dv !== 0) begin miscompares++; $display("FAIL empty_notoken got %b want 0", dv); end
    idone = 1; tick(); idone = 0; ird = 4'b1000; tick(); ird = 0;
    vectors++; if (outs !== 0 || err !== 1) begin miscompares++; $display("FAIL empty_sticky got %0d/%b want 0/1", outs, err); end
  endtask

  task automatic test_reset_mid();
    areset = 1; tick(); areset = 0; tick();
    for (int i = 0; i < 7; i++) begin iv = 1; ictl = 1; irid = RB'(i % NR); tick(); end
    iv = 0; idone = 1; repeat (3) tick(); idle();
    vectors++; if (outs !== 7 || dv !== 4'b0111) begin miscompares++; $display("FAIL mid_setup got %0d/%b want 7/0111", outs, dv); end
    areset = 1; tick();
    vectors++; if (rdy !== 0 || dv !== 0 || outs !== 0 || err !== 0) begin miscompares++; $display("FAIL mid_reset got %b/%b/%0d/%b want all 0", rdy, dv, outs, err); end
    areset = 0; tick();
    idone = 1; tick(); idone = 0;
    vectors++; if (err !== 1 || outs !== 0) begin miscompares++; $display("FAIL mid_postdone got %b/%0d want 1/0", err, outs); end
  endtask

  task automatic test_random();
    int pd, pr;
    areset = 1; tick(); areset = 0; tick();
    for (int c = 0; c < 3000; c++) begin
      pd = 10 + 30 * ((c / 200) % 3);
      pr = 70 - 30 * ((c / 300) % 3);
      areset = $urandom_range(0, 599) == 0;
      iv = $urandom_range(0, 1);
      irid = ($urandom_range(0, 19) != 0) ? RB'($urandom_range(0, NR - 1)) : RB'($urandom_range(NR, 15));
      ictl = $urandom_range(0, 2) != 0;
      idone = $urandom_range(0, 99) < pd;
      for (int r = 0; r < NR; r++) ird[r] = $urandom_range(0, 99) < pr;
      tick();
      vectors++; if (rdy !== m_rdy) begin miscompares++; $display("FAIL rand_ready c=%0d got %b want %b", c, rdy, m_rdy); end
      vectors++; if (dv !== m_valid()) begin miscompares++; $display("FAIL rand_valid c=%0d got %b want %b", c, dv, m_valid()); end
      vectors++; if (outs !== 6'(m_out())) begin miscompares++; $display("FAIL rand_out c=%0d got %0d want %0d", c, outs, m_out()); end
      vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rand_err c=%0d got %b want %b", c, err, m_err); end
    end
    areset = 0; idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_interleave();
    test_simul();
    test_empty_done();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
